// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants, used by the sync generator and the digit renderer.
package vga_pkg;
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int   COORD_W     = 11;
    localparam int   COORD_MAX   = (1 << COORD_W) - 1;
    localparam logic SYNC_ACTIVE = 1'b0;

    function automatic logic [COORD_W-1:0] coord(input int v);
        return COORD_W'(v);
    endfunction
endpackage

// File: rtl/vga_axis_cnt.sv
// One VGA timing axis: wrapping counter with registered sync decode and next-state visible flag.
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int VISIBLE = VGA_H_VISIBLE,
    parameter int FRONT   = VGA_H_FRONT,
    parameter int SYNC    = VGA_H_SYNC,
    parameter int BACK    = VGA_H_BACK
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [COORD_W-1:0] cnt,
    output logic               carry,
    output logic               vis_next,
    output logic               sinc
);
    localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
    localparam logic [COORD_W-1:0] LAST     = coord(TOTAL - 1);
    localparam logic [COORD_W-1:0] ONE      = coord(1);
    localparam logic [COORD_W-1:0] VIS_END  = coord(VISIBLE);
    localparam logic [COORD_W-1:0] SYNC_BEG = coord(VISIBLE + FRONT);
    localparam logic [COORD_W-1:0] SYNC_END = coord(VISIBLE + FRONT + SYNC);

    logic [COORD_W-1:0] cnt_next;
    logic               sinc_next;

    always_comb begin
        carry    = en && (cnt == LAST);
        cnt_next = cnt;
        if (carry)
            cnt_next = '0;
        else if (en)
            cnt_next = cnt + ONE;
    end

    // Decodes look at the next count so they land in the same cycle as it.
    always_comb begin
        vis_next  = (cnt_next < VIS_END);
        sinc_next = ((cnt_next >= SYNC_BEG) && (cnt_next < SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= LAST;
            sinc <= ~SYNC_ACTIVE;
        end else begin
            cnt  <= cnt_next;
            sinc <= sinc_next;
        end
    end
endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/coordinate generator; all outputs registered and mutually aligned.
// Define VGA_PIX_DIV2_EN to run from a 2x pixel clock (internal divide-by-2 strobe).
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               h_sinc,
    output logic               v_sinc,
    output logic               video_on,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               line_start,
    output logic               frame_start,
    output logic               pix_stb
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_range_chk
            $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the coordinate width");
        end
    endgenerate

    logic adv;

`ifdef VGA_PIX_DIV2_EN
    logic div_tgl;

    // Toggle starts at 0, so the first strobe is the second edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_tgl <= 1'b0;
        else
            div_tgl <= ~div_tgl;
    end

    assign adv = div_tgl;
`else
    assign adv = 1'b1;
`endif

    logic h_carry, v_carry;
    logic h_vis_next, v_vis_next;

    vga_axis_cnt #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (adv),
        .cnt      (pos_x),
        .carry    (h_carry),
        .vis_next (h_vis_next),
        .sinc     (h_sinc)
    );

    vga_axis_cnt #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (h_carry),
        .cnt      (pos_y),
        .carry    (v_carry),
        .vis_next (v_vis_next),
        .sinc     (v_sinc)
    );

    // A wrap on this strobe means the next pixel is column 0 (and row 0 on a frame wrap).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            pix_stb     <= 1'b0;
        end else begin
            pix_stb <= adv;
            if (adv) begin
                video_on    <= h_vis_next && v_vis_next;
                line_start  <= h_carry;
                frame_start <= h_carry && v_carry;
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for line timing, scaled-down instance for frame timing.
module tb_vga_sync_gen;
    import vga_pkg::*;

`ifdef VGA_PIX_DIV2_EN
    localparam int PER = 2;
`else
    localparam int PER = 1;
`endif

    localparam int SH_V = 10, SH_F = 2, SH_S = 3, SH_B = 4;
    localparam int SV_V = 5,  SV_F = 2, SV_S = 2, SV_B = 3;
    localparam int S_HT = SH_V + SH_F + SH_S + SH_B;
    localparam int S_VT = SV_V + SV_F + SV_S + SV_B;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        h;
        logic        v;
        logic        vid;
        logic        ls;
        logic        fs;
        logic        stb;
    } obs_t;

    typedef struct {
        string name;
        int    adv;
        obs_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst0_n, rst1_n;
    logic h0, v0, vid0, ls0, fs0, stb0;
    logic h1, v1, vid1, ls1, fs1, stb1;
    logic [10:0] x0, y0, x1, y1;
    int checks = 0;
    int failures = 0;
    int cyc0 = 0;
    int cyc1 = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_dut0 (
        .clk(clk), .rst_n(rst0_n), .h_sinc(h0), .v_sinc(v0), .video_on(vid0),
        .pos_x(x0), .pos_y(y0), .line_start(ls0), .frame_start(fs0), .pix_stb(stb0)
    );

    vga_sync_gen #(
        .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B)
    ) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .h_sinc(h1), .v_sinc(v1), .video_on(vid1),
        .pos_x(x1), .pos_y(y1), .line_start(ls1), .frame_start(fs1), .pix_stb(stb1)
    );

    // Reference: pixel index = strobes since release; coordinates by division/modulo.
    function automatic obs_t model(int cyc, int hv, int hf, int hs, int hb,
                                   int vv, int vf, int vs, int vb);
        int ht, vt, k, x, y;
        obs_t o;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        if (cyc / PER == 0) begin
            o.x = 11'(ht - 1); o.y = 11'(vt - 1);
            o.h = 1'b1; o.v = 1'b1; o.vid = 1'b0; o.ls = 1'b0; o.fs = 1'b0; o.stb = 1'b0;
            return o;
        end
        k = cyc / PER - 1;
        x = k % ht;
        y = (k / ht) % vt;
        o.x   = 11'(x);
        o.y   = 11'(y);
        o.vid = (x < hv) && (y < vv);
        o.h   = !((x >= hv + hf) && (x < hv + hf + hs));
        o.v   = !((y >= vv + vf) && (y < vv + vf + vs));
        o.ls  = (x == 0);
        o.fs  = (x == 0) && (y == 0);
        o.stb = (cyc % PER == 0);
        return o;
    endfunction

    function automatic obs_t m0(int cyc);
        return model(cyc, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t m1(int cyc);
        return model(cyc, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B);
    endfunction

    function automatic obs_t mk(int x, int y, logic h, logic v, logic vid, logic ls, logic fs, logic stb);
        obs_t o;
        o.x = 11'(x); o.y = 11'(y); o.h = h; o.v = v; o.vid = vid; o.ls = ls; o.fs = fs; o.stb = stb;
        return o;
    endfunction

    function automatic vec_t vec(string n, int a, obs_t e);
        vec_t r;
        r.name = n; r.adv = a; r.exp = e;
        return r;
    endfunction

    function automatic obs_t obs0();
        return mk(int'(x0), int'(y0), h0, v0, vid0, ls0, fs0, stb0);
    endfunction

    function automatic obs_t obs1();
        return mk(int'(x1), int'(y1), h1, v1, vid1, ls1, fs1, stb1);
    endfunction

    task automatic cmp(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b vid=%b ls=%b fs=%b stb=%b, want x=%0d y=%0d hs=%b vs=%b vid=%b ls=%b fs=%b stb=%b",
                     name, act.x, act.y, act.h, act.v, act.vid, act.ls, act.fs, act.stb,
                     exp.x, exp.y, exp.h, exp.v, exp.vid, exp.ls, exp.fs, exp.stb);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst0_n) cyc0++;
        if (rst1_n) cyc1++;
    endtask

    task automatic adv_pix(input int n);
        repeat (n * PER) tick();
    endtask

    initial begin
        vec_t vt[10];
        obs_t rexp0, rexp1;
        int vid_cnt, hs_cnt, hs_first, ls_cnt, ls_k0, ls_k1, k;
        int vs_cnt, fs_cnt, fs_k0, fs_k1, n;

        vt[0] = vec("first_pixel",  1,   mk(0,   0, 1, 1, 1, 1, 1, 1));
        vt[1] = vec("second_pixel", 1,   mk(1,   0, 1, 1, 1, 0, 0, 1));
        vt[2] = vec("last_visible", 638, mk(639, 0, 1, 1, 1, 0, 0, 1));
        vt[3] = vec("front_porch",  1,   mk(640, 0, 1, 1, 0, 0, 0, 1));
        vt[4] = vec("pre_hsync",    15,  mk(655, 0, 1, 1, 0, 0, 0, 1));
        vt[5] = vec("hsync_start",  1,   mk(656, 0, 0, 1, 0, 0, 0, 1));
        vt[6] = vec("hsync_last",   95,  mk(751, 0, 0, 1, 0, 0, 0, 1));
        vt[7] = vec("back_porch",   1,   mk(752, 0, 1, 1, 0, 0, 0, 1));
        vt[8] = vec("line_end",     47,  mk(799, 0, 1, 1, 0, 0, 0, 1));
        vt[9] = vec("line1_start",  1,   mk(0,   1, 1, 1, 1, 1, 0, 1));
        rexp0 = mk(799, 524, 1, 1, 0, 0, 0, 0);
        rexp1 = mk(S_HT - 1, S_VT - 1, 1, 1, 0, 0, 0, 0);

        rst0_n = 1'b0;
        rst1_n = 1'b0;
        repeat (3) tick();
        cmp("reset0", obs0(), rexp0);
        cmp("reset1", obs1(), rexp1);

        // Full-size instance: line timing from the table.
        rst0_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            adv_pix(vt[i].adv);
            cmp(vt[i].name, obs0(), vt[i].exp);
        end

        // Lines 1..2 against the model, counting line 2's decodes.
        vid_cnt = 0; hs_cnt = 0; hs_first = -1; ls_cnt = 0; ls_k0 = -1; ls_k1 = -1;
        while (cyc0 / PER < 2401) begin
            tick();
            cmp("line_model", obs0(), m0(cyc0));
            k = cyc0 / PER - 1;
            if (cyc0 % PER == 0) begin
                if (k >= 1600 && k < 2400) begin
                    vid_cnt += int'(vid0);
                    if (!h0) begin
                        hs_cnt++;
                        if (hs_first < 0) hs_first = int'(x0);
                    end
                    ls_cnt += int'(ls0);
                end
                if (ls0 && k >= 1600) begin
                    if (ls_k0 < 0) ls_k0 = k;
                    else if (ls_k1 < 0) ls_k1 = k;
                end
            end
        end
        cmp_int("video_on_per_line", vid_cnt, 640);
        cmp_int("hsync_low_per_line", hs_cnt, 96);
        cmp_int("hsync_first_x", hs_first, 656);
        cmp_int("line_start_per_line", ls_cnt, 1);
        cmp_int("line_period", ls_k1 - ls_k0, 800);

        // Async reset while h_sinc is low.
        adv_pix(700);
        cmp("pre_reset_x700", obs0(), mk(700, 3, 0, 1, 0, 0, 0, 1));
        rst0_n = 1'b0;
        cyc0 = 0;
        #1;
        cmp("reset0_async", obs0(), rexp0);
        tick();
        rst0_n = 1'b1;
        adv_pix(1);
        cmp("restart0", obs0(), mk(0, 0, 1, 1, 1, 1, 1, 1));
        rst0_n = 1'b0;
        cyc0 = 0;

        // Scaled-down instance: three whole frames against the model.
        rst1_n = 1'b1;
        vs_cnt = 0; fs_cnt = 0; fs_k0 = -1; fs_k1 = -1;
        while (cyc1 / PER < 3 * S_HT * S_VT) begin
            tick();
            cmp("frame_model", obs1(), m1(cyc1));
            k = cyc1 / PER - 1;
            if (cyc1 % PER == 0) begin
                if (k >= S_HT * S_VT && k < 2 * S_HT * S_VT) begin
                    vs_cnt += int'(!v1);
                    fs_cnt += int'(fs1);
                end
                if (fs1 && k > 0) begin
                    if (fs_k0 < 0) fs_k0 = k;
                    else if (fs_k1 < 0) fs_k1 = k;
                end
                if (k == 2 * S_HT * S_VT - 1)
                    cmp("wrap_before", obs1(), mk(S_HT - 1, S_VT - 1, 1, 1, 0, 0, 0, 1));
                if (k == 2 * S_HT * S_VT)
                    cmp("wrap_after", obs1(), mk(0, 0, 1, 1, 1, 1, 1, 1));
            end
        end
        cmp_int("vsync_low_per_frame", vs_cnt, SV_S * S_HT);
        cmp_int("frame_start_per_frame", fs_cnt, 1);
        cmp_int("frame_period", fs_k1 - fs_k0, S_HT * S_VT);

        // Reset during both syncs: column 13 of line 7.
        adv_pix(7 * S_HT + 13 + 1);
        cmp("pre_reset_sync", obs1(), mk(13, 7, 0, 0, 0, 0, 0, 1));
        rst1_n = 1'b0;
        cyc1 = 0;
        #1;
        cmp("reset1_async", obs1(), rexp1);
        tick();
        rst1_n = 1'b1;
        adv_pix(1);
        cmp("restart1", obs1(), mk(0, 0, 1, 1, 1, 1, 1, 1));

        // Random run lengths and random async reset points.
        repeat (8) begin
            n = int'($urandom_range(1, 300));
            repeat (n * PER) begin
                tick();
                cmp("random_run", obs1(), m1(cyc1));
            end
            #($urandom_range(0, 2));
            rst1_n = 1'b0;
            cyc1 = 0;
            #1;
            cmp("random_reset", obs1(), rexp1);
            repeat ($urandom_range(1, 3)) tick();
            rst1_n = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA timing: horizontal/vertical sync, a display-enable, and the current pixel coordinate. It is the source side of the pixel interface that the digit renderer consumes. The renderer draws HH:MM:SS from `pos_x`, `pos_y` and `video_on` instead of keeping its own free-running counters. All outputs are registered and mutually aligned, so downstream colour logic needs no skew correction.

## Interface
- `H_VISIBLE`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BACK`, 48: horizontal back porch, in pixels
- `V_VISIBLE`, 480: active lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BACK`, 33: vertical back porch, in lines
- `clk`  in  1  system clock: 25 MHz pixel clock, or 50 MHz when `VGA_PIX_DIV2_EN` is defined
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `h_sinc`  out  1  horizontal sync, active-low
- `v_sinc`  out  1  vertical sync, active-low
- `video_on`  out  1  high when the current pixel is inside the visible area
- `pos_x`  out  11  current pixel column, 0..H_TOTAL-1
- `pos_y`  out  11  current line, 0..V_TOTAL-1
- `line_start`  out  1  one-pixel pulse at `pos_x==0`
- `frame_start`  out  1  one-pixel pulse at (`pos_x`,`pos_y`)==(0,0)
- `pix_stb`  out  1  high on the clk cycles in which a new pixel is presented

The one clock is `clk`; reset is asynchronous and active-low (`rst_n`).

## Operation
- Derived values: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Order along a line: visible region, then front porch, then sync, then back porch. Same order for a frame.
- Horizontal counter behaviour on each pixel strobe:
  - increments by 1;
  - at H_TOTAL-1 it wraps to 0 and the vertical counter advances;
  - the vertical counter wraps from V_TOTAL-1 to 0.
- Decodes:
  - `video_on` = (x < H_VISIBLE) && (y < V_VISIBLE).
  - `h_sinc` = 0 iff H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - `v_sinc` = 0 iff y is in 490..491.
- Output alignment: all decodes are computed from next-state counter values and registered, so they are valid in the same cycle as the matching `pos_x`/`pos_y`.
- Outputs change only on pixel strobes and hold between strobes.
- Width rules: counters are 11 bits unsigned. H_TOTAL and V_TOTAL must be ≤ 2047; this is checked by an elaboration-time assertion.
- Reset values (async, while `rst_n`=0):
  - `pos_x` = H_TOTAL-1, `pos_y` = V_TOTAL-1
  - `h_sinc` = 1, `v_sinc` = 1
  - `video_on` = 0, `line_start` = 0, `frame_start` = 0, `pix_stb` = 0
- After reset release: the first pixel strobe presents (0,0) with `video_on`=1, `line_start`=1 and `frame_start`=1.
- Reset mid-frame: takes effect immediately. No partial sync pulse is extended; `h_sinc` and `v_sinc` go high asynchronously.

## Timing
- Latency from pixel strobe to outputs: 1 clk (registered).
- Line period is H_TOTAL strobes; frame period is H_TOTAL*V_TOTAL = 420000 strobes.
- `line_start` is high for exactly one strobe period per line.
- `frame_start` is high for exactly one strobe period per frame, and coincides with `line_start`.
- `v_sinc` transitions coincide with `pos_x`==0 of lines 490 and 492.

## Configuration
- `VGA_PIX_DIV2_EN` defined:
  - an internal toggle flop divides `clk` by 2;
  - counters advance only when the toggle is 1;
  - `pix_stb` is high every other cycle;
  - the toggle resets to 0, so the first strobe occurs on the 2nd clk edge after reset release.
- `VGA_PIX_DIV2_EN` undefined:
  - every clk is a pixel;
  - `pix_stb` is tied to 1 once out of reset.
- In both cases each output is held for one full pixel period.

## Structure
- Shared package `vga_pkg` holds:
  - the default 640x480 timing constants;
  - derived H_TOTAL/V_TOTAL;
  - the coordinate width constant (11);
  - the sync polarity constant (active-low).
- The renderer imports the same package.
- One sub-module is natural: `vga_axis_cnt`, a wrapping counter with sync/visible decode. It is instantiated twice, once for horizontal and once for vertical; the vertical instance is enabled by the horizontal wrap.

## Test plan
- Reset: hold `rst_n`=0, release, then first strobe → `pos_x`=0, `pos_y`=0, `video_on`=1, `frame_start`=1, `h_sinc`=1, `v_sinc`=1.
- Horizontal timing: count strobes over one line:
  - `video_on` high for 640 strobes;
  - `h_sinc` low for exactly 96 strobes, starting at `pos_x`=656;
  - line length 800.
- Vertical timing: run one full frame:
  - `v_sinc` low for exactly 1600 strobes, i.e. lines 490–491;
  - `frame_start` period 420000 strobes;
  - `pos_y` wraps 524→0.
- Wrap corner: at (799,524) the next strobe gives (0,0) with `line_start`=1 and `frame_start`=1 in the same cycle.
- Reset mid-operation: assert `rst_n`=0 at `pos_x`=700 during sync (line 490) → `h_sinc`=1 and `v_sinc`=1 immediately and `pos_x`=799; after release, normal restart at (0,0).
- `VGA_PIX_DIV2_EN` build: `pix_stb` alternates 0/1, each `pos_x` value is held for 2 clk, and the line takes 1600 clk.
